// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM states, owner encoding and bus widths for mem_arbiter
package mem_arbiter_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MASK_W = 8;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
   typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one pmem port between fetch (ifu) and load/store (lsu)
//   clk/reset          : single clock, synchronous active-high reset
//   ifu_*              : fetch request (valid/ready/addr) and response (rvalid/rdata)
//   lsu_*              : load/store request (valid/ready/addr/wen/wdata/wmask) and response
//   mem_*              : latched request to pmem (valid/ready handshake) and its response
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ifu_valid,
   output logic              ifu_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rvalid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [MASK_W-1:0] lsu_wmask,
   output logic              lsu_rvalid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wen,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_e            state_q, state_d;
   owner_e            owner_q, owner_d, last_q, last_d, pick;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wen_q, wen_d;
   logic [MASK_W-1:0] wmask_q, wmask_d;
   logic              grant, rsp, pick_lsu;

   // contention goes to whoever was not served last; a lone requester always wins
   function automatic owner_e rr_pick(input logic iv, input logic lv, input owner_e last);
      return (iv && lv) ? ((last == OWN_IFU) ? OWN_LSU : OWN_IFU) : (lv ? OWN_LSU : OWN_IFU);
   endfunction

   assign mem_valid = (state_q == REQ);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wen   = wen_q;
   assign mem_wmask = wmask_q;

   // handshake outputs are masked during reset so an abandoned transaction never completes
   always_comb begin
      pick       = rr_pick(ifu_valid, lsu_valid, last_q);
      pick_lsu   = (pick == OWN_LSU);
      grant      = !reset && (state_q == IDLE) && (ifu_valid || lsu_valid);
      rsp        = !reset && (state_q == WAIT) && mem_rvalid;
      ifu_ready  = grant && !pick_lsu;
      lsu_ready  = grant && pick_lsu;
      ifu_rvalid = rsp && (owner_q == OWN_IFU);
      lsu_rvalid = rsp && (owner_q == OWN_LSU);
      ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
      lsu_rdata  = (lsu_rvalid && !wen_q) ? mem_rdata : '0;
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wen_d      = wen_q;
      wmask_d    = wmask_q;
      if (grant) begin
         state_d = REQ;
         owner_d = pick;
         last_d  = pick;
         addr_d  = pick_lsu ? lsu_addr : ifu_addr;
         wdata_d = pick_lsu ? lsu_wdata : '0;
         wen_d   = pick_lsu && lsu_wen;
         wmask_d = (pick_lsu && lsu_wen) ? lsu_wmask : '0;
      end
      if (state_q == REQ && mem_ready) state_d = WAIT;
      if (rsp) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= OWN_IFU;
         last_q  <= OWN_LSU;
         addr_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         wmask_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         wmask_q <= wmask_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   logic        clk = 0, reset = 1;
   logic        ifu_valid = 0, ifu_ready, ifu_rvalid;
   logic [31:0] ifu_addr = 0, ifu_rdata;
   logic        lsu_valid = 0, lsu_ready, lsu_wen = 0, lsu_rvalid;
   logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
   logic [7:0]  lsu_wmask = 0;
   logic        mem_valid, mem_ready = 0, mem_wen, mem_rvalid = 0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
   logic [7:0]  mem_wmask;
   int          tests = 0, fails = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
      .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one full transaction while both requesters hold valid; exp_lsu selects the expected winner
   task automatic contend(input string tag, input logic exp_lsu);
      #1;
      chk({tag, "_ifu_ready"}, ifu_ready, !exp_lsu);
      chk({tag, "_lsu_ready"}, lsu_ready, exp_lsu);
      cyc();
      chk({tag, "_mem_valid"}, mem_valid, 1);
      chk({tag, "_mem_addr"}, mem_addr, exp_lsu ? 32'h8000_0100 : 32'h8000_0000);
      chk({tag, "_mem_wmask"}, mem_wmask, 0);
      chk({tag, "_no_ready"}, {ifu_ready, lsu_ready}, 0);
      cyc();
      mem_rvalid = 1;
      mem_rdata  = exp_lsu ? 32'h0000_1111 : 32'h0000_2222;
      #1;
      chk({tag, "_ifu_rvalid"}, ifu_rvalid, !exp_lsu);
      chk({tag, "_lsu_rvalid"}, lsu_rvalid, exp_lsu);
      chk({tag, "_rdata"}, exp_lsu ? lsu_rdata : ifu_rdata, mem_rdata);
      chk({tag, "_bubble"}, {ifu_ready, lsu_ready}, 0);
      cyc();
      mem_rvalid = 0;
   endtask

   initial begin
      cyc();
      ifu_valid = 1;
      #1;
      chk("rst_ifu_ready", ifu_ready, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
      ifu_valid = 0;
      cyc();
      reset = 0;
      // fetch only
      ifu_valid = 1;
      ifu_addr  = 32'h8000_0000;
      mem_ready = 1;
      #1;
      chk("f_ifu_ready", ifu_ready, 1);
      chk("f_lsu_ready", lsu_ready, 0);
      chk("f_mem_valid0", mem_valid, 0);
      cyc();
      ifu_valid = 0;
      #1;
      chk("f_mem_valid", mem_valid, 1);
      chk("f_mem_addr", mem_addr, 32'h8000_0000);
      chk("f_mem_wen", mem_wen, 0);
      chk("f_ifu_ready1", ifu_ready, 0);
      cyc();
      chk("f_wait_mem_valid", mem_valid, 0);
      chk("f_wait_no_rvalid", ifu_rvalid, 0);
      mem_rvalid = 1;
      mem_rdata  = 32'h0010_0073;
      #1;
      chk("f_ifu_rvalid", ifu_rvalid, 1);
      chk("f_ifu_rdata", ifu_rdata, 32'h0010_0073);
      chk("f_lsu_rvalid", lsu_rvalid, 0);
      cyc();
      mem_rvalid = 0;
      #1;
      chk("f_rvalid_pulse", ifu_rvalid, 0);
      // contention after reset: IFU, LSU, IFU, LSU
      reset = 1;
      cyc();
      reset     = 0;
      ifu_valid = 1;
      lsu_valid = 1;
      lsu_addr  = 32'h8000_0100;
      lsu_wen   = 0;
      lsu_wmask = 8'hFF;
      contend("c1", 0);
      contend("c2", 1);
      contend("c3", 0);
      contend("c4", 1);
      ifu_valid = 0;
      // store with 5 cycles of backpressure
      lsu_wen   = 1;
      lsu_addr  = 32'h8000_1000;
      lsu_wdata = 32'hDEAD_BEEF;
      lsu_wmask = 8'h01;
      mem_ready = 0;
      #1;
      chk("s_lsu_ready", lsu_ready, 1);
      chk("s_ifu_ready", ifu_ready, 0);
      cyc();
      chk("s_mem_wen", mem_wen, 1);
      chk("s_mem_wmask", mem_wmask, 8'h01);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_mem_valid", i), mem_valid, 1);
         chk($sformatf("bp%0d_mem_addr", i), mem_addr, 32'h8000_1000);
         chk($sformatf("bp%0d_no_ready", i), {ifu_ready, lsu_ready}, 0);
         cyc();
      end
      mem_ready = 1;
      #1;
      chk("bp_still_req", mem_valid, 1);
      cyc();
      chk("bp_wait", mem_valid, 0);
      lsu_valid  = 0;
      mem_rvalid = 1;
      mem_rdata  = 32'h1234_5678;
      #1;
      chk("s_lsu_rvalid", lsu_rvalid, 1);
      chk("s_lsu_rdata", lsu_rdata, 0);
      chk("s_ifu_rvalid", ifu_rvalid, 0);
      cyc();
      // stray mem_rvalid in IDLE
      #1;
      chk("stray_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
      cyc();
      mem_rvalid = 0;
      #1;
      chk("stray_idle", mem_valid, 0);
      // reset during WAIT, then late mem_rvalid
      ifu_valid = 1;
      ifu_addr  = 32'h8000_0040;
      cyc();
      ifu_valid = 0;
      cyc();
      chk("rw_in_wait", mem_valid, 0);
      reset = 1;
      cyc();
      reset      = 0;
      mem_rvalid = 1;
      mem_rdata  = 32'hBAD0_BAD0;
      #1;
      chk("rw_late_rvalid", {ifu_rvalid, lsu_rvalid}, 0);
      chk("rw_mem_valid", mem_valid, 0);
      chk("rw_mem_addr", mem_addr, 0);
      cyc();
      mem_rvalid = 0;
      ifu_valid  = 1;
      ifu_addr   = 32'h8000_0080;
      #1;
      chk("rw_fresh_ready", ifu_ready, 1);
      cyc();
      ifu_valid = 0;
      chk("rw_fresh_valid", mem_valid, 1);
      chk("rw_fresh_addr", mem_addr, 32'h8000_0080);
      cyc();
      mem_rvalid = 1;
      mem_rdata  = 32'h0000_0013;
      #1;
      chk("rw_fresh_rvalid", ifu_rvalid, 1);
      chk("rw_fresh_rdata", ifu_rdata, 32'h0000_0013);
      cyc();
      mem_rvalid = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
